// File: rtl/exec_unit_cdb.sv
// exec_unit_cdb: fixed-latency integer unit feeding the CDB through a credit-limited result FIFO.
// Optional macro EXEC_OVF_EN adds BCovf, the signed-overflow flag of the broadcast add/sub result.
module exec_unit_cdb #(
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        issueValid,
    output logic        issueReady,
    input  logic [1:0]  opIn,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic [4:0]  tagIn,
    output logic        cdbReq,
    input  logic        cdbGrant,
    output logic        BCEN,
    output logic [4:0]  BClabel,
    output logic [31:0] BCdata
`ifdef EXEC_OVF_EN
    ,
    output logic        BCovf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Issue handshake: an instruction transfers in a cycle with issueValid && issueReady and
    // tagIn != 0. issueReady depends only on registered state, never on issueValid.

    logic [31:0]    w_alu;
    logic [4:0]     w_inflight;
    logic [4:0]     w_used;
    logic           w_accept;
    logic           w_push;
    logic           w_pop;

    logic [LAT-1:0] r_pv;
    logic [4:0]     r_ptag  [LAT];
    logic [31:0]    r_pdata [LAT];

    logic [4:0]     r_btag  [DEPTH];
    logic [31:0]    r_bdata [DEPTH];
    logic [AW-1:0]  r_head;
    logic [AW-1:0]  r_tail;
    logic [CW-1:0]  r_count;

`ifdef EXEC_OVF_EN
    logic           w_ovf;
    logic           r_povf  [LAT];
    logic           r_bovf  [DEPTH];
`endif

    always_comb begin
        w_alu = '0;
        unique case (opIn)
            2'b00:   w_alu = srcA + srcB;
            2'b01:   w_alu = srcA - srcB;
            2'b10:   w_alu = srcA & srcB;
            default: w_alu = srcA | srcB;
        endcase
    end

`ifdef EXEC_OVF_EN
    // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips.
    always_comb begin
        w_ovf = 1'b0;
        unique case (opIn)
            2'b00:   w_ovf = (srcA[31] == srcB[31]) && (w_alu[31] != srcA[31]);
            2'b01:   w_ovf = (srcA[31] != srcB[31]) && (w_alu[31] != srcA[31]);
            default: w_ovf = 1'b0;
        endcase
    end
`endif

    // Every valid stage already owns a buffer slot, so the pipeline never needs to stall.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            w_inflight = w_inflight + 5'(r_pv[i]);
        end
    end

    assign w_used     = w_inflight + 5'(r_count);
    assign issueReady = (w_used < 5'(DEPTH));
    assign w_accept   = issueValid && issueReady && (tagIn != 5'd0);
    assign w_push     = r_pv[LAT-1];
    assign w_pop      = BCEN;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_pv <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_ptag[i]  <= '0;
                r_pdata[i] <= '0;
`ifdef EXEC_OVF_EN
                r_povf[i]  <= 1'b0;
`endif
            end
        end else begin
            r_pv[0] <= w_accept;
            if (w_accept) begin
                r_ptag[0]  <= tagIn;
                r_pdata[0] <= w_alu;
`ifdef EXEC_OVF_EN
                r_povf[0]  <= w_ovf;
`endif
            end
            for (int i = 1; i < LAT; i++) begin
                r_pv[i]    <= r_pv[i-1];
                r_ptag[i]  <= r_ptag[i-1];
                r_pdata[i] <= r_pdata[i-1];
`ifdef EXEC_OVF_EN
                r_povf[i]  <= r_povf[i-1];
`endif
            end
        end
    end

    // Result FIFO; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_btag[i]  <= '0;
                r_bdata[i] <= '0;
`ifdef EXEC_OVF_EN
                r_bovf[i]  <= 1'b0;
`endif
            end
        end else begin
            if (w_push) begin
                r_btag[r_tail]  <= r_ptag[LAT-1];
                r_bdata[r_tail] <= r_pdata[LAT-1];
`ifdef EXEC_OVF_EN
                r_bovf[r_tail]  <= r_povf[LAT-1];
`endif
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign cdbReq  = (r_count != '0);
    assign BCEN    = cdbReq && cdbGrant;
    assign BClabel = cdbReq ? r_btag[r_head]  : 5'd0;
    assign BCdata  = cdbReq ? r_bdata[r_head] : 32'd0;
`ifdef EXEC_OVF_EN
    assign BCovf   = BCEN && r_bovf[r_head];
`endif

endmodule

// File: tb/tb_exec_unit_cdb.sv
// Self-checking bench for exec_unit_cdb: randomized issue/grant traffic against a queue-based model.
module tb_exec_unit_cdb;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  localparam logic [1:0]  AR_OP  [5] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
  localparam logic [31:0] AR_A   [5] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'hF0F0_1234, 32'h0F00_0001, 32'h8000_0000};
  localparam logic [31:0] AR_B   [5] = '{32'h0000_0001, 32'h0000_0001, 32'h0FF0_FF00, 32'hF000_00F0, 32'h0000_0001};
  localparam logic [31:0] AR_RES [5] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h00F0_1200, 32'hFF00_00F1, 32'h7FFF_FFFF};
  localparam logic [4:0]  AR_TAG [5] = '{5'd9, 5'd4, 5'd5, 5'd6, 5'd8};
  localparam logic        AR_OVF [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  // clock / reset
  logic clk  = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  logic        issueValid = 1'b0;
  logic [1:0]  opIn       = 2'b00;
  logic [31:0] srcA       = 32'd0;
  logic [31:0] srcB       = 32'd0;
  logic [4:0]  tagIn      = 5'd0;
  logic        cdbGrant   = 1'b0;
  logic        issueReady;
  logic        cdbReq;
  logic        BCEN;
  logic [4:0]  BClabel;
  logic [31:0] BCdata;
`ifdef EXEC_OVF_EN
  logic        BCovf;
`endif

  exec_unit_cdb #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .nRST       (nRST),
    .issueValid (issueValid),
    .issueReady (issueReady),
    .opIn       (opIn),
    .srcA       (srcA),
    .srcB       (srcB),
    .tagIn      (tagIn),
    .cdbReq     (cdbReq),
    .cdbGrant   (cdbGrant),
    .BCEN       (BCEN),
    .BClabel    (BClabel),
`ifdef EXEC_OVF_EN
    .BCovf      (BCovf),
`endif
    .BCdata     (BCdata)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int push_full_events = 0;

  // scoreboard: every accepted op not yet broadcast, oldest first, with the cycle it becomes visible
  logic [36:0] exp_q[$];
  logic        ovf_q[$];
  int          avail_q[$];

  logic        e_ready, e_req, e_bcen, e_ovf, will_acc;
  logic [4:0]  e_label, p_tag;
  logic [31:0] e_data, p_a, p_b;
  logic [1:0]  p_op;

  function automatic logic [31:0] ref_val(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 2'b00) r = sa + sb;
    else if (op == 2'b01) r = sa - sb;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic string obs_str();
    return $sformatf("rdy=%b req=%b en=%b lbl=%0d dat=%h", issueReady, cdbReq, BCEN, BClabel, BCdata);
  endfunction

  function automatic string exp_str();
    return $sformatf("rdy=%b req=%b en=%b lbl=%0d dat=%h", e_ready, e_req, e_bcen, e_label, e_data);
  endfunction

  task automatic clear_model();
    exp_q.delete();
    ovf_q.delete();
    avail_q.delete();
    will_acc = 1'b0;
    e_bcen   = 1'b0;
  endtask

  // driver: apply one cycle of inputs just after negedge and compute the expected outputs
  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input logic g);
    issueValid = v; opIn = op; srcA = a; srcB = b; tagIn = t; cdbGrant = g;
    p_op = op; p_a = a; p_b = b; p_tag = t;
    #1;
    e_ready  = (exp_q.size() < DEPTH);
    e_req    = (exp_q.size() != 0) && (avail_q[0] <= cyc);
    e_bcen   = e_req && g;
    e_label  = e_req ? exp_q[0][36:32] : 5'd0;
    e_data   = e_req ? exp_q[0][31:0] : 32'd0;
    e_ovf    = e_bcen ? ovf_q[0] : 1'b0;
    will_acc = v && e_ready && (t != 5'd0);
  endtask

  task automatic advance();
    @(posedge clk);
    cyc++;
    if (e_bcen) begin
      void'(exp_q.pop_front());
      void'(ovf_q.pop_front());
      void'(avail_q.pop_front());
    end
    if (will_acc) begin
      exp_q.push_back({p_tag, ref_val(p_op, p_a, p_b)});
      ovf_q.push_back(ref_ovf(p_op, p_a, p_b));
      avail_q.push_back(cyc + LAT);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) begin
      drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 1'b1);
      advance();
    end
  endtask

  task automatic issue_and_wait(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] t, output bit found, output int lat,
                                output logic [31:0] dat, output logic ovf, output bit dropped);
    int acc_cyc;
    found = 0; lat = -1; dat = 32'd0; ovf = 1'b0; dropped = 0; acc_cyc = -100;
    drive(1'b1, op, a, b, t, 1'b1);
    if (issueReady !== 1'b1) dropped = 1;
    if (will_acc) acc_cyc = cyc + 1;
    advance();
    for (int k = 0; k < 12 && !found; k++) begin
      drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 1'b1);
      if (issueReady !== 1'b1) dropped = 1;
      if (BCEN === 1'b1 && BClabel === t) begin
        found = 1;
        lat   = cyc - acc_cyc;
        dat   = BCdata;
`ifdef EXEC_OVF_EN
        ovf   = BCovf;
`endif
      end
      advance();
    end
  endtask

  // flags any push into a full result buffer
  always @(negedge clk) begin
    #2;
    if (nRST === 1'b1 && dut.w_push === 1'b1 && dut.w_pop !== 1'b1 && dut.r_count == DEPTH)
      push_full_events++;
  end

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({issueReady, cdbReq, BCEN, BClabel, BCdata} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_state got %s want rdy=1 req=0 en=0 lbl=0 dat=0", obs_str());
    end
`ifdef EXEC_OVF_EN
    n_tests++;
    if (BCovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", BCovf); end
`endif
    #1 nRST = 1'b1;
    @(negedge clk);
    cyc = 0;
    clear_model();
  endtask

  task automatic test_single_op();
    bit found, dropped; int lat; logic [31:0] dat; logic ovf;
    issue_and_wait(2'b00, 32'd5, 32'd7, 5'd3, found, lat, dat, ovf, dropped);
    n_tests++;
    if (!found || lat != LAT || dat !== 32'd12) begin
      n_fail++;
      $display("FAIL single_op found=%0d lat=%0d dat=%h want found=1 lat=%0d dat=0000000c", found, lat, dat, LAT);
    end
    n_tests++;
    if (dropped) begin n_fail++; $display("FAIL single_op_ready got issueReady=0 want 1 throughout"); end
    drain();
  endtask

  task automatic test_arith();
    bit found, dropped; int lat; logic [31:0] dat; logic ovf;
    for (int i = 0; i < 5; i++) begin
      issue_and_wait(AR_OP[i], AR_A[i], AR_B[i], AR_TAG[i], found, lat, dat, ovf, dropped);
      n_tests++;
      if (!found || dat !== AR_RES[i]) begin
        n_fail++;
        $display("FAIL arith_%0d found=%0d dat=%h want %h", i, found, dat, AR_RES[i]);
      end
`ifdef EXEC_OVF_EN
      n_tests++;
      if (ovf !== AR_OVF[i]) begin n_fail++; $display("FAIL arith_ovf_%0d got %b want %b", i, ovf, AR_OVF[i]); end
`endif
      drain();
    end
  endtask

  task automatic test_tag0();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, 5'd0, 1'b1);
      n_tests++;
      if (BCEN !== 1'b0 || issueReady !== 1'b1 ||
          {issueReady, cdbReq, BCEN, BClabel, BCdata} !== {e_ready, e_req, e_bcen, e_label, e_data}) begin
        n_fail++;
        $display("FAIL tag0 cyc=%0d got %s want %s", cyc, obs_str(), exp_str());
      end
      advance();
    end
    for (int k = 0; k < LAT + 2; k++) begin
      drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 1'b1);
      n_tests++;
      if (cdbReq !== 1'b0) begin n_fail++; $display("FAIL tag0_stale cyc=%0d got req=%b want 0", cyc, cdbReq); end
      advance();
    end
  endtask

  task automatic test_back_pressure();
    logic [4:0] seen[$];
    for (int t = 1; t <= 4; t++) begin
      drive(1'b1, 2'b00, $urandom, $urandom, 5'(t), 1'b0);
      n_tests++;
      if ({issueReady, cdbReq, BCEN, BClabel, BCdata} !== {e_ready, e_req, e_bcen, e_label, e_data}) begin
        n_fail++;
        $display("FAIL bp_fill cyc=%0d got %s want %s", cyc, obs_str(), exp_str());
      end
      advance();
    end
    for (int k = 0; k <= LAT; k++) begin
      drive(1'b1, 2'b00, $urandom, $urandom, 5'd20, 1'b0);
      n_tests++;
      if (issueReady !== 1'b0 || cdbReq !== 1'b1 || BClabel !== 5'd1 ||
          {issueReady, cdbReq, BCEN, BClabel, BCdata} !== {e_ready, e_req, e_bcen, e_label, e_data}) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got %s want %s", cyc, obs_str(), exp_str());
      end
      advance();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 1'b1);
      n_tests++;
      if ({issueReady, cdbReq, BCEN, BClabel, BCdata} !== {e_ready, e_req, e_bcen, e_label, e_data}) begin
        n_fail++;
        $display("FAIL bp_release cyc=%0d got %s want %s", cyc, obs_str(), exp_str());
      end
      if (BCEN === 1'b1) seen.push_back(BClabel);
      advance();
    end
    n_tests++;
    if (seen.size() != 4) begin
      n_fail++;
      $display("FAIL bp_order got %0d broadcasts want 4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (seen[i] !== 5'(i + 1)) begin n_fail++; $display("FAIL bp_order_%0d got tag %0d want %0d", i, seen[i], i + 1); end
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [4:0] seen[$];
    for (int k = 0; k < 24; k++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, 5'(k + 1), 1'b1);
      n_tests++;
      if ({issueReady, cdbReq, BCEN, BClabel, BCdata} !== {e_ready, e_req, e_bcen, e_label, e_data}) begin
        n_fail++;
        $display("FAIL b2b cyc=%0d got %s want %s", cyc, obs_str(), exp_str());
      end
      if (BCEN === 1'b1) seen.push_back(BClabel);
      advance();
    end
    for (int k = 0; k < 20 && seen.size() < 24; k++) begin
      drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 1'b1);
      n_tests++;
      if ({issueReady, cdbReq, BCEN, BClabel, BCdata} !== {e_ready, e_req, e_bcen, e_label, e_data}) begin
        n_fail++;
        $display("FAIL b2b_tail cyc=%0d got %s want %s", cyc, obs_str(), exp_str());
      end
      if (BCEN === 1'b1) seen.push_back(BClabel);
      advance();
    end
    n_tests++;
    if (seen.size() != 24) begin
      n_fail++;
      $display("FAIL b2b_count got %0d broadcasts want 24", seen.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        n_tests++;
        if (seen[i] !== 5'(i + 1)) begin n_fail++; $display("FAIL b2b_order_%0d got tag %0d want %0d", i, seen[i], i + 1); end
      end
    end
    drain();
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int k = 0; k < 200; k++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), a, b,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 2) != 0));
      n_tests++;
      if ({issueReady, cdbReq, BCEN, BClabel, BCdata} !== {e_ready, e_req, e_bcen, e_label, e_data}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got %s want %s", cyc, obs_str(), exp_str());
      end
`ifdef EXEC_OVF_EN
      n_tests++;
      if (BCovf !== e_ovf) begin n_fail++; $display("FAIL random_ovf cyc=%0d got %b want %b", cyc, BCovf, e_ovf); end
`endif
      advance();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bit found, dropped; int lat; logic [31:0] dat, a, b; logic ovf;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, 5'(10 + k), 1'b1);
      advance();
    end
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 1'b1);
    n_tests++;
    if (BCEN !== 1'b1 || {issueReady, cdbReq, BCEN, BClabel, BCdata} !== {e_ready, e_req, e_bcen, e_label, e_data}) begin
      n_fail++;
      $display("FAIL rst_mid_pre cyc=%0d got %s want %s", cyc, obs_str(), exp_str());
    end
    #1 nRST = 1'b0;
    #1;
    n_tests++;
    if ({issueReady, cdbReq, BCEN, BClabel, BCdata} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL rst_mid_async got %s want rdy=1 req=0 en=0 lbl=0 dat=0", obs_str());
    end
    clear_model();
    @(posedge clk);
    @(negedge clk);
    nRST = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 1'b1);
      n_tests++;
      if (cdbReq !== 1'b0 || BCEN !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_stale cyc=%0d got req=%b en=%b want 0 0", cyc, cdbReq, BCEN);
      end
      advance();
    end
    a = $urandom; b = $urandom;
    issue_and_wait(2'b00, a, b, 5'd7, found, lat, dat, ovf, dropped);
    n_tests++;
    if (!found || lat != LAT || dat !== a + b) begin
      n_fail++;
      $display("FAIL rst_mid_new found=%0d lat=%0d dat=%h want found=1 lat=%0d dat=%h", found, lat, dat, LAT, a + b);
    end
    drain();
  endtask

  initial begin
    clear_model();
    test_reset();
    test_single_op();
    test_arith();
    test_tag0();
    test_back_pressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    n_tests++;
    if (push_full_events != 0) begin
      n_fail++;
      $display("FAIL push_full got %0d pushes into a full buffer want 0", push_full_events);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
